// File: rtl/sa_cache_nway_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_cache_nway_ctrl
// Purpose  : N-way set-associative, write-back, write-allocate cache
//            controller with true-LRU replacement. There is one data word
//            per line. The tag, valid, dirty, age and data arrays are
//            internal. They are read asynchronously, indexed from the
//            latched request.
// Ports    : clk, rst (synchronous, active-low)
//            cpu_valid/cpu_rw/cpu_addr/cpu_wdata  : CPU request in
//            cpu_rdata/cpu_ready/cpu_stall        : CPU response out
//            mem_valid/mem_rw/mem_addr/mem_wdata  : memory request out
//            mem_rdata/mem_ready                  : memory response in
//            hit_cnt/miss_cnt/wb_cnt              : only with CACHE_PERF_CNT_EN
// Options  : `define CACHE_PERF_CNT_EN adds saturating 32-bit perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module sa_cache_nway_ctrl #(
    parameter int  WAYS    = 4,
    parameter int  INDEX_W = 10,
    parameter int  TAG_W   = 10,
    parameter int  DATA_W  = 32,
    localparam int ADDR_W  = TAG_W + INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt
`endif
);

    localparam int c_SETS  = 1 << INDEX_W;
    localparam int c_AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_COMPARE    = 3'd2,
        S_WRITE_BACK = 3'd3,
        S_ALLOCATE   = 3'd4
    } state_t;

    // Storage arrays
    logic [TAG_W-1:0]   r_tag   [c_SETS][WAYS];
    logic [DATA_W-1:0]  r_data  [c_SETS][WAYS];
    logic [c_AGE_W-1:0] r_age   [c_SETS][WAYS];
    logic [WAYS-1:0]    r_valid [c_SETS];
    logic [WAYS-1:0]    r_dirty [c_SETS];

    // Control state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_sweep;
    logic               r_req_rw;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [DATA_W-1:0]  r_req_wdata;
    logic [c_AGE_W-1:0] r_victim;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [WAYS-1:0]    w_match;
    logic               w_hit;
    logic [c_AGE_W-1:0] w_hit_way;
    logic [c_AGE_W-1:0] w_inv_way;
    logic [c_AGE_W-1:0] w_lru_way;
    logic               w_any_inv;
    logic [c_AGE_W-1:0] w_victim;
    logic               w_accept;

    assign w_idx    = r_req_addr[INDEX_W-1:0];
    assign w_tag    = r_req_addr[ADDR_W-1:INDEX_W];
    assign w_accept = cpu_valid && !cpu_stall;

    // Tag lookup and victim selection. The loop runs from the top way down,
    // so the last assignment wins and the lowest-numbered invalid way is the
    // one that is kept.
    always_comb begin
        w_match   = '0;
        w_hit_way = '0;
        w_inv_way = '0;
        w_lru_way = '0;
        w_any_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_match[w] = 1'b1;
                w_hit_way  = c_AGE_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_any_inv = 1'b1;
                w_inv_way = c_AGE_W'(w);
            end
            if (r_age[w_idx][w] == c_AGE_W'(WAYS - 1)) begin
                w_lru_way = c_AGE_W'(w);
            end
        end
        // A hit requires exactly one matching way.
        w_hit    = $onehot(w_match);
        w_victim = w_any_inv ? w_inv_way : w_lru_way;
    end

    // Next-state and output decode. While rst is low, every output holds its
    // quiet value.
    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        cpu_stall   = 1'b1;
        cpu_rdata   = '0;
        mem_valid   = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst) begin
            case (r_state)
                S_INIT: begin
                    if (r_sweep == INDEX_W'(c_SETS - 1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    cpu_stall = 1'b0;
                    if (cpu_valid) begin
                        w_state_nxt = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        cpu_stall   = 1'b0;
                        cpu_ready   = 1'b1;
                        cpu_rdata   = r_data[w_idx][w_hit_way];
                        w_state_nxt = cpu_valid ? S_COMPARE : S_IDLE;
                    end else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                        w_state_nxt = S_WRITE_BACK;
                    end else begin
                        w_state_nxt = S_ALLOCATE;
                    end
                end
                S_WRITE_BACK: begin
                    mem_valid = 1'b1;
                    mem_rw    = 1'b1;
                    mem_addr  = {r_tag[w_idx][r_victim], w_idx};
                    mem_wdata = r_data[w_idx][r_victim];
                    if (mem_ready) begin
                        w_state_nxt = S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    mem_valid = 1'b1;
                    mem_addr  = r_req_addr;
                    if (mem_ready) begin
                        w_state_nxt = S_COMPARE;
                    end
                end
                default: w_state_nxt = S_INIT;
            endcase
        end
    end

    // State register, sweep index, request register and victim latch
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_req_rw    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_victim    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_sweep <= r_sweep + 1'b1;
            end
            if (w_accept) begin
                r_req_rw    <= cpu_rw;
                r_req_addr  <= cpu_addr;
                r_req_wdata <= cpu_wdata;
            end
            if ((r_state == S_COMPARE) && !w_hit) begin
                r_victim <= w_victim;
            end
        end
    end

    // Array updates. The INIT sweep restores the ages to the identity
    // permutation. On a hit, the ages are updated as a true LRU; the old ages
    // are read here because the assignments are non-blocking. A write hit uses
    // the write data latched with the request. This matters because the CPU
    // may already be presenting its next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            case (r_state)
                S_INIT: begin
                    r_valid[r_sweep] <= '0;
                    r_dirty[r_sweep] <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        r_age[r_sweep][w] <= c_AGE_W'(w);
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (c_AGE_W'(w) == w_hit_way) begin
                                r_age[w_idx][w] <= '0;
                            end else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way]) begin
                                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                            end
                        end
                        if (r_req_rw) begin
                            r_data[w_idx][w_hit_way]  <= r_req_wdata;
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ready) begin
                        r_data[w_idx][r_victim]  <= mem_rdata;
                        r_tag[w_idx][r_victim]   <= w_tag;
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // r_refilled marks the COMPARE pass that follows a refill. That pass is a
    // guaranteed hit, and it is not counted as a first-pass hit.
    logic r_refilled;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            wb_cnt     <= '0;
            r_refilled <= 1'b0;
        end else begin
            if ((r_state == S_ALLOCATE) && mem_ready) begin
                r_refilled <= 1'b1;
            end else if (r_state == S_COMPARE) begin
                r_refilled <= 1'b0;
            end
            if ((r_state == S_COMPARE) && w_hit && !r_refilled && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if ((r_state == S_COMPARE) && !w_hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if ((r_state == S_WRITE_BACK) && mem_ready && (wb_cnt != '1)) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sa_cache_nway_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sa_cache_nway_ctrl
// Purpose  : Directed self-checking bench for sa_cache_nway_ctrl with the
//            default configuration (4 ways, 10 index bits, 10 tag bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_cache_nway_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_stall;
    logic        mem_valid;
    logic        mem_rw;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] wb_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa_cache_nway_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_stall (cpu_stall),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until it is accepted. On return, the DUT
    // is in the cycle after the accept, which is COMPARE.
    task automatic req(input logic rw, input logic [19:0] a, input logic [31:0] d);
        int n = 0;
        cpu_valid = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = d;
        while (cpu_stall && n < 50) begin
            tick();
            n++;
        end
        check("req_accept", cpu_stall, 1'b0);
        tick();
        cpu_valid = 1'b0;
    endtask

    task automatic mem_done(input logic [31:0] rd);
        mem_rdata = rd;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    // Issue a read and service every memory request until it completes.
    task automatic fill(input logic [19:0] a, input logic [31:0] rd);
        int n = 0;
        req(1'b0, a, '0);
        while (!cpu_ready && n < 20) begin
            if (mem_valid) mem_done(rd);
            else tick();
            n++;
        end
        check("fill_ready", cpu_ready, 1'b1);
        check("fill_rdata", cpu_rdata, rd);
        tick();
    endtask

    // Count the cycles spent in the INIT sweep. The count starts at the
    // sample taken right after rst has been released.
    task automatic init_count(input string tag);
        int  cnt  = 0;
        logic seen = 1'b0;
        while (cpu_stall && cnt < 2000) begin
            if (mem_valid) seen = 1'b1;
            tick();
            cnt++;
        end
        check({tag, "_cycles"}, cnt, 1024);
        check({tag, "_no_mem"}, seen, 1'b0);
    endtask

    logic [19:0] b2b_addr [4];
    logic [31:0] b2b_data [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b2b_addr = '{20'h01005, 20'h00405, 20'h00805, 20'h00C05};
        b2b_data = '{32'h44, 32'h11, 32'h22, 32'h33};

        // Reset state
        repeat (3) tick();
        check("rst_stall", cpu_stall, 1'b1);
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 20'h0);
        rst = 1'b1;
        init_count("init");
        check("init_done_stall", cpu_stall, 1'b0);

        // Read miss refills from memory
        req(1'b0, 20'h00005, '0);
        check("rmiss_ready", cpu_ready, 1'b0);
        check("rmiss_stall", cpu_stall, 1'b1);
        tick();
        check("rmiss_mem_valid", mem_valid, 1'b1);
        check("rmiss_mem_rw", mem_rw, 1'b0);
        check("rmiss_mem_addr", mem_addr, 20'h00005);
        mem_done(32'hDEADBEEF);
        check("rmiss_done_ready", cpu_ready, 1'b1);
        check("rmiss_done_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Read hit
        req(1'b0, 20'h00005, '0);
        check("rhit_ready", cpu_ready, 1'b1);
        check("rhit_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rhit_no_mem", mem_valid, 1'b0);
        tick();

        // Write hit, then read back
        req(1'b1, 20'h00005, 32'hA5A5A5A5);
        check("whit_ready", cpu_ready, 1'b1);
        tick();
        req(1'b0, 20'h00005, '0);
        check("whit_readback", cpu_rdata, 32'hA5A5A5A5);
        tick();

        // Fill index 5. The dirty tag 0 line ends up as the LRU way.
        fill(20'h00405, 32'h11);
        fill(20'h00805, 32'h22);
        fill(20'h00C05, 32'h33);
        req(1'b0, 20'h01005, '0);
        tick();
        check("wb_mem_valid", mem_valid, 1'b1);
        check("wb_mem_rw", mem_rw, 1'b1);
        check("wb_mem_addr", mem_addr, 20'h00005);
        check("wb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        check("wb_hold_addr", mem_addr, 20'h00005);
        check("wb_hold_rw", mem_rw, 1'b1);
        mem_done(32'h0);
        check("alloc_mem_rw", mem_rw, 1'b0);
        check("alloc_mem_addr", mem_addr, 20'h01005);
        mem_done(32'h44);
        check("alloc_ready", cpu_ready, 1'b1);
        check("alloc_rdata", cpu_rdata, 32'h44);
        tick();

        // LRU order at index 7. After tag 0 is re-read, tag 1 is the LRU line.
        fill(20'h00007, 32'h70);
        fill(20'h00407, 32'h71);
        fill(20'h00807, 32'h72);
        fill(20'h00C07, 32'h73);
        req(1'b0, 20'h00007, '0);
        check("lru_t0_hit", cpu_ready, 1'b1);
        tick();
        req(1'b0, 20'h01407, '0);
        check("lru_t5_miss", cpu_ready, 1'b0);
        tick();
        check("lru_clean_victim", mem_rw, 1'b0);
        check("lru_alloc_addr", mem_addr, 20'h01407);
        mem_done(32'h75);
        check("lru_t5_rdata", cpu_rdata, 32'h75);
        tick();
        req(1'b0, 20'h00007, '0);
        check("lru_t0_still_hit", cpu_ready, 1'b1);
        check("lru_t0_rdata", cpu_rdata, 32'h70);
        tick();
        req(1'b0, 20'h00407, '0);
        check("lru_t1_evicted", cpu_ready, 1'b0);
        tick();
        check("lru_t1_refill_rw", mem_rw, 1'b0);
        mem_done(32'h71);
        check("lru_t1_ready", cpu_ready, 1'b1);
        tick();

        // Back-to-back hits with cpu_valid held
        cpu_valid = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = b2b_addr[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cpu_addr = b2b_addr[i+1];
            else cpu_valid = 1'b0;
            check("b2b_ready", cpu_ready, 1'b1);
            check("b2b_stall", cpu_stall, 1'b0);
            check("b2b_rdata", cpu_rdata, b2b_data[i]);
            tick();
        end

        // Make tag 4 at index 5 dirty and LRU, then reset during its write-back
        req(1'b1, 20'h01005, 32'hBEEF0001);
        check("rstwb_whit", cpu_ready, 1'b1);
        tick();
        for (int i = 1; i < 4; i++) begin
            req(1'b0, b2b_addr[i], '0);
            check("rstwb_hit", cpu_ready, 1'b1);
            tick();
        end
        req(1'b0, 20'h01405, '0);
        tick();
        check("rstwb_mem_rw", mem_rw, 1'b1);
        check("rstwb_mem_addr", mem_addr, 20'h01005);
        check("rstwb_mem_wdata", mem_wdata, 32'hBEEF0001);
        rst = 1'b0;
        tick();
        check("rstwb_mem_dropped", mem_valid, 1'b0);
        check("rstwb_stall", cpu_stall, 1'b1);
        tick();
        rst = 1'b1;
        init_count("reinit");
        req(1'b0, 20'h01005, '0);
        check("reinit_miss", cpu_ready, 1'b0);
        tick();
        check("reinit_mem_rw", mem_rw, 1'b0);
        check("reinit_mem_addr", mem_addr, 20'h01005);
        mem_done(32'h55);
        check("reinit_rdata", cpu_rdata, 32'h55);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
